// File: rtl/cog_alu_muldiv.sv
// ---------------------------------------------------------------------------
// cog_alu_muldiv
// Iterative multiply/divide unit that sits beside the cog ALU. It performs
// unsigned and signed multiply (full double-width product) and unsigned and
// signed divide (quotient plus remainder) on WIDTH-bit operands, one step per
// clock. Results are shaped like the ALU's r/co/zo so that writeback can merge
// them directly.
//
// Handshake: start is sampled on a rising edge only when the unit is not busy
// (state IDLE or FIN). On that edge the request is accepted, and no further
// request is taken until FIN. busy is high exactly while the FSM is in RUN.
// done is a one-cycle pulse during FIN, when r/rx/co/zo are valid. A start
// that arrives while busy is dropped, not queued.
//
// Ports:
//   clk_cog    cog clock; all state changes happen on its rising edge
//   res        synchronous active-high reset
//   start      request; sampled only when not busy
//   op         00 MUL, 01 MULS, 10 DIV, 11 DIVS
//   d, s       multiplicand/dividend, multiplier/divisor
//   busy       operation in progress (state RUN)
//   done       one-cycle result-valid pulse (state FIN)
//   r, rx      product low/high half, or quotient/remainder
//   co         overflow / divide-error flag
//   zo         zero flag
//   dbg_state  FSM state, exposed for checkers (0 IDLE, 1 RUN, 2 FIN)
//
// Optional feature, macro COG_ALU_MULDIV_EARLY_EN: when this macro is
// defined, MUL/MULS leave RUN as soon as the remaining multiplier bits are
// all zero. Results stay the same and divide latency does not change.
// ---------------------------------------------------------------------------
module cog_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk_cog,
  input  logic             res,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] rx,
  output logic             co,
  output logic             zo,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic               neg_q;   // MUL: product negative; DIV: quotient negative
  logic               neg_r;   // DIV: remainder negative (sign of dividend)
  // Product accumulator for MUL. For DIV, acc[WIDTH:0] holds the partial
  // remainder.
  logic [2*WIDTH-1:0] acc;
  // Shifted multiplicand for MUL. For DIV, mc[WIDTH-1:0] holds the divisor
  // magnitude.
  logic [2*WIDTH-1:0] mc;
  // Unconsumed multiplier bits for MUL. For DIV, this holds dividend bits
  // that shift out and quotient bits that shift in.
  logic [WIDTH-1:0]   mp;

  logic               is_div;
  logic               is_signed;
  logic               accept;
  logic               d_neg;
  logic               s_neg;
  logic [WIDTH-1:0]   d_mag;
  logic [WIDTH-1:0]   s_mag;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] mc_step;
  logic [WIDTH-1:0]   mp_step;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     rem_n;
  logic               ge;
  logic               last;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_f;
  logic [WIDTH-1:0]   rem_f;
  logic [WIDTH-1:0]   fin_r;
  logic [WIDTH-1:0]   fin_rx;
  logic               fin_co;
  logic               fin_zo;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign accept    = start && (state == ST_IDLE || state == ST_FIN);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_FIN);
  assign dbg_state = state;

  // Operand magnitudes at accept time. Negating the most-negative value gives
  // the same bit pattern, and that pattern is the correct unsigned magnitude.
  always_comb begin
    d_neg = op[0] & d[WIDTH-1];
    s_neg = op[0] & s[WIDTH-1];
    d_mag = d_neg ? (WIDTH'(0) - d) : d;
    s_mag = s_neg ? (WIDTH'(0) - s) : s;
  end

  // One iteration step, plus the sign-corrected result that the FSM
  // registers when this step is the last one.
  always_comb begin
    acc_step = acc;
    mc_step  = mc;
    mp_step  = mp;
    shifted  = '0;
    rem_n    = '0;
    ge       = 1'b0;
    if (is_div) begin
      // Restoring division: shift in the next dividend bit, then subtract the
      // divisor if it fits.
      shifted  = {acc[WIDTH-1:0], mp[WIDTH-1]};
      ge       = (shifted >= {1'b0, mc[WIDTH-1:0]});
      rem_n    = ge ? (shifted - {1'b0, mc[WIDTH-1:0]}) : shifted;
      acc_step = {{(WIDTH-1){1'b0}}, rem_n};
      mp_step  = {mp[WIDTH-2:0], ge};
    end else begin
      acc_step = mp[0] ? (acc + mc) : acc;
      mc_step  = mc << 1;
      mp_step  = mp >> 1;
    end

`ifdef COG_ALU_MULDIV_EARLY_EN
    last = (cnt == '0) || (!is_div && mp_step == '0);
`else
    last = (cnt == '0);
`endif

    prod  = neg_q ? ((2*WIDTH)'(0) - acc_step) : acc_step;
    quo_f = neg_q ? (WIDTH'(0) - mp_step) : mp_step;
    rem_f = neg_r ? (WIDTH'(0) - acc_step[WIDTH-1:0]) : acc_step[WIDTH-1:0];

    if (is_div) begin
      fin_r  = quo_f;
      fin_rx = rem_f;
      // A positive quotient with its top bit set can only come from
      // most-negative / -1.
      fin_co = is_signed & ~neg_q & mp_step[WIDTH-1];
      fin_zo = (quo_f == '0);
    end else begin
      fin_r  = prod[WIDTH-1:0];
      fin_rx = prod[2*WIDTH-1:WIDTH];
      fin_co = is_signed ? (fin_rx != {WIDTH{prod[WIDTH-1]}})
                         : (fin_rx != '0);
      fin_zo = (prod == '0);
    end
  end

  always_ff @(posedge clk_cog) begin
    if (res) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= 2'b00;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      acc   <= '0;
      mc    <= '0;
      mp    <= '0;
      r     <= '0;
      rx    <= '0;
      co    <= 1'b0;
      zo    <= 1'b0;
    end else if (accept) begin
      op_q  <= op;
      neg_q <= d_neg ^ s_neg;
      neg_r <= d_neg;
      acc   <= '0;
      cnt   <= CNT_INIT;
      if (op[1]) begin
        mc <= {{WIDTH{1'b0}}, s_mag};
        mp <= d_mag;
      end else begin
        mc <= {{WIDTH{1'b0}}, d_mag};
        mp <= s_mag;
      end
      if (op[1] && s == '0) begin
        // Divide by zero skips RUN. The results are fixed values.
        state <= ST_FIN;
        r     <= '1;
        rx    <= d;
        co    <= 1'b1;
        zo    <= 1'b0;
      end else begin
        state <= ST_RUN;
      end
    end else begin
      case (state)
        ST_RUN: begin
          acc <= acc_step;
          mc  <= mc_step;
          mp  <= mp_step;
          cnt <= cnt - 1'b1;
          if (last) begin
            state <= ST_FIN;
            r     <= fin_r;
            rx    <= fin_rx;
            co    <= fin_co;
            zo    <= fin_zo;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cog_alu_muldiv.sv
// ---------------------------------------------------------------------------
// Directed bench for cog_alu_muldiv at WIDTH=32. Latency is counted in rising
// edges from the accept edge (the accept edge itself counts as 1) up to the
// edge after which done is high. For a normal op this is 32 RUN cycles + 1.
// ---------------------------------------------------------------------------
module tb_cog_alu_muldiv;

  localparam int W = 32;
`ifdef COG_ALU_MULDIV_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk_cog = 1'b0;
  logic         res = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] d = '0;
  logic [W-1:0] s = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] r;
  logic [W-1:0] rx;
  logic         co;
  logic         zo;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;
  int lat;
  bit saw_busy;
  bit first_busy;
  int pulses_before;

  cog_alu_muldiv #(.WIDTH(W)) dut (
    .clk_cog  (clk_cog),
    .res      (res),
    .start    (start),
    .op       (op),
    .d        (d),
    .s        (s),
    .busy     (busy),
    .done     (done),
    .r        (r),
    .rx       (rx),
    .co       (co),
    .zo       (zo),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_cog = ~clk_cog;

  always @(negedge clk_cog) if (done) done_pulses++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps edge by edge until done is seen #1 after an edge. The caller has
  // already raised start, so the first edge is the accept edge.
  task automatic wait_done(input bit drop_start, output int n, output bit any_busy,
                           output bit busy_first);
    n = 0;
    any_busy = 1'b0;
    busy_first = 1'b0;
    forever begin
      @(posedge clk_cog);
      #1;
      n++;
      if (n == 1) begin
        busy_first = busy;
        if (drop_start) start = 1'b0;
      end
      if (busy) any_busy = 1'b1;
      if (done || n > 200) break;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] dd, input logic [W-1:0] ss);
    @(negedge clk_cog);
    op = o; d = dd; s = ss; start = 1'b1;
    wait_done(1'b1, lat, saw_busy, first_busy);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] er, input logic [W-1:0] erx,
                           input logic eco, input logic ezo);
    check({tag, ".r"}, 64'(r), 64'(er));
    check({tag, ".rx"}, 64'(rx), 64'(erx));
    check({tag, ".co"}, 64'(co), 64'(eco));
    check({tag, ".zo"}, 64'(zo), 64'(ezo));
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk_cog);
    #1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.state", 64'(dbg_state), 64'd0);
    check_res("rst", 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk_cog);
    res = 1'b0;

    // MUL unsigned with overflow into the high half
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2);
    check("mul.lat", 64'(lat), EARLY ? 64'd3 : 64'd33);
    check_res("mul", 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);

    // MULS -3 * 5 = -15
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5);
    check("muls.lat", 64'(lat), EARLY ? 64'd4 : 64'd33);
    check_res("muls", 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // MUL zero product
    run_op(2'b00, 32'h0, 32'h1234);
    check("mul0.lat", 64'(lat), EARLY ? 64'd14 : 64'd33);
    check_res("mul0", 32'h0, 32'h0, 1'b0, 1'b1);

    // DIV 100 / 7
    run_op(2'b10, 32'd100, 32'd7);
    check("div.lat", 64'(lat), 64'd33);
    check_res("div", 32'd14, 32'd2, 1'b0, 1'b0);

    // DIVS -100 / 7 = -14 rem -2
    run_op(2'b11, 32'hFFFF_FF9C, 32'd7);
    check_res("divs", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // DIVS most-negative / -1 wraps with an overflow flag
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    check_res("divs_ovf", 32'h8000_0000, 32'h0, 1'b1, 1'b0);

    // Divide by zero skips RUN
    run_op(2'b10, 32'h55, 32'h0);
    check("div0.lat", 64'(lat), 64'd1);
    check("div0.busy", 64'(saw_busy), 64'd0);
    check_res("div0", 32'hFFFF_FFFF, 32'h55, 1'b1, 1'b0);

    // Results are held after FIN
    repeat (4) @(posedge clk_cog);
    #1;
    check("hold.r", 64'(r), 64'hFFFF_FFFF);
    check("hold.done", 64'(done), 64'd0);

    // start held high through RUN is ignored, then accepted in FIN
    pulses_before = done_pulses;
    @(negedge clk_cog);
    op = 2'b00; d = 32'd3; s = 32'd5; start = 1'b1;
    wait_done(1'b0, lat, saw_busy, first_busy);
    check("hs1.lat", 64'(lat), EARLY ? 64'd4 : 64'd33);
    check("hs1.r", 64'(r), 64'd15);
    d = 32'd6; s = 32'd7;            // presented during the FIN cycle
    wait_done(1'b1, lat, saw_busy, first_busy);
    check("hs2.busy_next", 64'(first_busy), 64'd1);
    check("hs2.lat", 64'(lat), EARLY ? 64'd4 : 64'd33);
    check("hs2.r", 64'(r), 64'd42);
    @(posedge clk_cog);
    #1;
    check("hs.pulses", 64'(done_pulses - pulses_before), 64'd2);

    // reset mid-RUN when the counter is 10 (21 edges after the accept edge)
    @(negedge clk_cog);
    op = 2'b10; d = 32'd100; s = 32'd7; start = 1'b1;
    @(posedge clk_cog);
    #1;
    start = 1'b0;
    repeat (21) @(posedge clk_cog);
    @(negedge clk_cog);
    check("mid.busy_before", 64'(busy), 64'd1);
    res = 1'b1;
    @(posedge clk_cog);
    #1;
    res = 1'b0;
    check("mid.busy", 64'(busy), 64'd0);
    check("mid.done", 64'(done), 64'd0);
    check_res("mid", 32'h0, 32'h0, 1'b0, 1'b0);
    pulses_before = done_pulses;
    repeat (40) @(posedge clk_cog);
    #1;
    check("mid.no_done", 64'(done_pulses - pulses_before), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
